alarm_scheduler: RTL and testbench

Multi-slot alarm controller for the clock datapath. It holds NUM_SLOTS programmable alarm times and compares them against the running time on each second tick. It sequences the ringer through ring, snooze and dismiss, and drives the single ring output consumed by the buzzer/LED logic. It replaces free-running per-alarm comparators with one registered scheduler that owns the ring resource.

---
 rtl/alarm_scheduler.sv | 167 ++++++++++++++++
 tb/tb_alarm_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: NUM_SLOTS programmable alarm times sharing one registered ringer.
// Snooze support (target registers, snooze counter) is built only with ALARM_SNOOZE_EN defined.
module alarm_scheduler #(
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned SLOT_W     = 2,
   parameter int unsigned RING_SECS  = 60,
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned MAX_SNOOZE = 3
) (
   input  logic              clk_ac,
   input  logic              reset,
   input  logic              sec_tick,
   input  logic [17:0]       clock_inp,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [17:0]       wr_time,
   input  logic              wr_enable,
   input  logic              dismiss,
   input  logic              snooze,
   output logic              ot_ac,
   output logic [SLOT_W-1:0] active_slot,
   output logic [1:0]        state,
   output logic [1:0]        snooze_left
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RING   = 2'b01,
      S_SNOOZE = 2'b10
   } state_t;

   state_t              cur_q, nxt;
   logic [17:0]         slot_time_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_en_q;
   logic [7:0]          ring_cnt_q, ring_cnt_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [1:0]          left_q, left_d;
   logic                ot_q;
   logic                match_any;
   logic [SLOT_W-1:0]   match_idx;
   logic                cancel;
   logic                ring_done;

`ifdef ALARM_SNOOZE_EN
   logic [17:0] tgt_q, tgt_d;
   logic [17:0] snz_target;
   logic [6:0]  mm_sum;
   logic [5:0]  hh_next;

   always_comb begin
      mm_sum  = {1'b0, clock_inp[11:6]} + 7'(SNOOZE_MIN);
      hh_next = clock_inp[17:12];
      if (mm_sum >= 7'd60) begin
         mm_sum  = mm_sum - 7'd60;
         hh_next = (clock_inp[17:12] == 6'd23) ? '0 : clock_inp[17:12] + 6'd1;
      end
      snz_target = {hh_next, mm_sum[5:0], clock_inp[5:0]};
   end
`else
   logic [9:0] unused_snooze_cfg;
   assign unused_snooze_cfg = {snooze, 7'(SNOOZE_MIN), 2'(MAX_SNOOZE)};
`endif

   // Scan high-to-low so the lowest matching index is the one left standing.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (slot_en_q[NUM_SLOTS-1-i] && (slot_time_q[NUM_SLOTS-1-i] == clock_inp)) begin
            match_any = 1'b1;
            match_idx = SLOT_W'(NUM_SLOTS-1-i);
         end
      end
   end

   assign cancel    = wr_en && (wr_slot == slot_q) && !wr_enable;
   assign ring_done = (({1'b0, ring_cnt_q} + 9'd1) == 9'(RING_SECS));

   always_comb begin
      nxt        = cur_q;
      slot_d     = slot_q;
      left_d     = left_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      tgt_d      = tgt_q;
`endif
      case (cur_q)
         S_IDLE: begin
            if (sec_tick && match_any) begin
               nxt        = S_RING;
               slot_d     = match_idx;
               ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
               left_d     = 2'(MAX_SNOOZE);
`endif
            end
         end
         S_RING: begin
            if (dismiss || cancel) begin
               nxt = S_IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze && (left_q != 2'd0)) begin
               nxt    = S_SNOOZE;
               tgt_d  = snz_target;
               left_d = left_q - 2'd1;
`endif
            end else if (sec_tick) begin
               ring_cnt_d = ring_cnt_q + 8'd1;
               if (ring_done) begin
                  nxt = S_IDLE;
               end
            end
         end
`ifdef ALARM_SNOOZE_EN
         S_SNOOZE: begin
            if (dismiss || cancel) begin
               nxt = S_IDLE;
            end else if (sec_tick && (clock_inp == tgt_q)) begin
               nxt        = S_RING;
               ring_cnt_d = '0;
            end
         end
`endif
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_ac) begin
      if (reset) begin
         cur_q      <= S_IDLE;
         slot_q     <= '0;
         left_q     <= '0;
         ring_cnt_q <= '0;
         ot_q       <= 1'b0;
         slot_en_q  <= '0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_time_q[i] <= '0;
         end
      end else begin
         cur_q      <= nxt;
         slot_q     <= slot_d;
         left_q     <= left_d;
         ring_cnt_q <= ring_cnt_d;
         ot_q       <= (nxt == S_RING);
         if (wr_en && (32'(wr_slot) < NUM_SLOTS)) begin
            slot_time_q[wr_slot] <= wr_time;
            slot_en_q[wr_slot]   <= wr_enable;
         end
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk_ac) begin
      if (reset) begin
         tgt_q <= '0;
      end else begin
         tgt_q <= tgt_d;
      end
   end
`endif

   assign ot_ac       = ot_q;
   assign active_slot = slot_q;
   assign state       = cur_q;
   assign snooze_left = left_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a time-of-day based reference model.
module tb_alarm_scheduler;

   localparam int NS = 4;
   localparam int SW = 2;
   localparam int RS = 60;
   localparam int SM = 5;
   localparam int MS = 3;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic          clk_ac    = 1'b0;
   logic          reset     = 1'b1;
   logic          sec_tick  = 1'b0;
   logic [17:0]   clock_inp = '0;
   logic          wr_en     = 1'b0;
   logic [SW-1:0] wr_slot   = '0;
   logic [17:0]   wr_time   = '0;
   logic          wr_enable = 1'b0;
   logic          dismiss   = 1'b0;
   logic          snooze    = 1'b0;
   logic          ot_ac;
   logic [SW-1:0] active_slot;
   logic [1:0]    state;
   logic [1:0]    snooze_left;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: state 0 idle, 1 ringing, 2 snoozed; target kept as seconds of day.
   logic [17:0] m_time [NS];
   bit          m_en   [NS];
   int          m_st, m_slot, m_left, m_cnt, m_tgt;
   logic [17:0] pool   [8];

   alarm_scheduler #(
      .NUM_SLOTS (NS),
      .SLOT_W    (SW),
      .RING_SECS (RS),
      .SNOOZE_MIN(SM),
      .MAX_SNOOZE(MS)
   ) dut (
      .clk_ac     (clk_ac),
      .reset      (reset),
      .sec_tick   (sec_tick),
      .clock_inp  (clock_inp),
      .wr_en      (wr_en),
      .wr_slot    (wr_slot),
      .wr_time    (wr_time),
      .wr_enable  (wr_enable),
      .dismiss    (dismiss),
      .snooze     (snooze),
      .ot_ac      (ot_ac),
      .active_slot(active_slot),
      .state      (state),
      .snooze_left(snooze_left)
   );

   always #5 clk_ac = ~clk_ac;

   function automatic int tod(logic [17:0] t);
      return int'(t[17:12]) * 3600 + int'(t[11:6]) * 60 + int'(t[5:0]);
   endfunction

   function automatic logic [17:0] from_tod(int s);
      return {6'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
   endfunction

   function automatic logic [17:0] hms(int h, int m, int s);
      return {6'(h), 6'(m), 6'(s)};
   endfunction

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      bit cancel;
      if (reset) begin
         for (int i = 0; i < NS; i++) begin
            m_time[i] = '0;
            m_en[i]   = 1'b0;
         end
         m_st = 0; m_slot = 0; m_left = 0; m_cnt = 0; m_tgt = 0;
         return;
      end
      cancel = wr_en && (int'(wr_slot) == m_slot) && !wr_enable;
      if (m_st == 0) begin
         if (sec_tick) begin
            for (int i = 0; i < NS; i++) begin
               if (m_en[i] && m_time[i] == clock_inp) begin
                  m_st = 1; m_slot = i; m_left = SNZ ? MS : 0; m_cnt = 0;
                  break;
               end
            end
         end
      end else if (dismiss || cancel) begin
         m_st = 0;
      end else if (m_st == 1 && SNZ && snooze && m_left > 0) begin
         m_st   = 2;
         m_left = m_left - 1;
         m_tgt  = (tod(clock_inp) + SM * 60) % 86400;
      end else if (sec_tick) begin
         if (m_st == 1) begin
            m_cnt++;
            if (m_cnt == RS) m_st = 0;
         end else if (tod(clock_inp) == m_tgt) begin
            m_st  = 1;
            m_cnt = 0;
         end
      end
      if (wr_en) begin
         m_time[wr_slot] = wr_time;
         m_en[wr_slot]   = wr_enable;
      end
   endfunction

   task automatic step();
      model_step();
      @(posedge clk_ac);
      #2;
   endtask

   task automatic tick_at(logic [17:0] t);
      sec_tick  = 1'b1;
      clock_inp = t;
      step();
      sec_tick  = 1'b0;
   endtask

   task automatic wr(int slot, logic [17:0] t, bit en);
      wr_en     = 1'b1;
      wr_slot   = SW'(slot);
      wr_time   = t;
      wr_enable = en;
      step();
      wr_en     = 1'b0;
   endtask

   task automatic press_snooze(logic [17:0] t);
      clock_inp = t;
      snooze    = 1'b1;
      step();
      snooze    = 1'b0;
   endtask

   // Per-cycle comparison against the model.
   always @(posedge clk_ac) begin
      #1;
      if (chk_en) begin
         check("ot_ac", int'(ot_ac), (m_st == 1) ? 1 : 0);
         check("state", int'(state), m_st);
         if (m_st != 0) begin
            check("active_slot", int'(active_slot), m_slot);
            check("snooze_left", int'(snooze_left), m_left);
         end
      end
   end

   initial begin
      pool[0] = hms(7, 30, 0);
      pool[1] = hms(12, 0, 0);
      pool[2] = hms(23, 57, 10);
      pool[3] = hms(0, 2, 10);
      pool[4] = hms(23, 59, 59);
      pool[5] = hms(0, 0, 0);
      pool[6] = hms(23, 58, 30);
      pool[7] = hms(9, 55, 5);

      reset = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      check("rst_ot", int'(ot_ac), 0);
      check("rst_state", int'(state), 0);
      check("rst_slot", int'(active_slot), 0);
      check("rst_left", int'(snooze_left), 0);

      wr(1, hms(7, 30, 0), 1'b1);
      tick_at(hms(7, 30, 0));
      check("m1_ot", int'(ot_ac), 1);
      check("m1_slot", int'(active_slot), 1);
      check("m1_state", int'(state), 1);
      check("m1_left", int'(snooze_left), SNZ ? 3 : 0);
      dismiss = 1'b1;
      step();
      dismiss = 1'b0;
      check("dis_ot", int'(ot_ac), 0);
      check("dis_state", int'(state), 0);

      wr(0, hms(12, 0, 0), 1'b1);
      wr(2, hms(12, 0, 0), 1'b1);
      tick_at(hms(12, 0, 0));
      check("prio_slot", int'(active_slot), 0);
      check("prio_ot", int'(ot_ac), 1);
      dismiss = 1'b1;
      snooze  = 1'b1;
      step();
      dismiss = 1'b0;
      snooze  = 1'b0;
      check("dis_snz_state", int'(state), 0);
      check("dis_snz_ot", int'(ot_ac), 0);

      wr(3, hms(23, 57, 10), 1'b1);
      tick_at(hms(23, 57, 10));
      check("late_slot", int'(active_slot), 3);
      press_snooze(hms(23, 57, 10));
`ifdef ALARM_SNOOZE_EN
      check("snz_state", int'(state), 2);
      check("snz_left", int'(snooze_left), 2);
      check("snz_ot", int'(ot_ac), 0);
      tick_at(hms(0, 2, 9));
      check("snz_early_ot", int'(ot_ac), 0);
      tick_at(hms(0, 2, 10));
      check("rering_ot", int'(ot_ac), 1);
      check("rering_state", int'(state), 1);
      press_snooze(hms(0, 2, 10));
      tick_at(hms(0, 7, 10));
      press_snooze(hms(0, 7, 10));
      tick_at(hms(0, 12, 10));
      check("exh_left", int'(snooze_left), 0);
      check("exh_state", int'(state), 1);
      press_snooze(hms(0, 12, 30));
`endif
      check("snz_ign_state", int'(state), 1);
      check("snz_ign_left", int'(snooze_left), 0);
      for (int i = 0; i < RS - 1; i++) tick_at(hms(1, 0, 0));
      check("auto_pre_state", int'(state), 1);
      tick_at(hms(1, 0, 0));
      check("auto_state", int'(state), 0);
      check("auto_ot", int'(ot_ac), 0);

      tick_at(hms(7, 30, 0));
      check("cx_slot", int'(active_slot), 1);
      wr(1, hms(7, 30, 0), 1'b1);
      check("keep_state", int'(state), 1);
      wr(1, hms(7, 30, 0), 1'b0);
      check("cancel_state", int'(state), 0);
      check("cancel_ot", int'(ot_ac), 0);

      tick_at(hms(12, 0, 0));
      check("rr_ot", int'(ot_ac), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rr_ot0", int'(ot_ac), 0);
      check("rr_state", int'(state), 0);
      check("rr_slot", int'(active_slot), 0);
      check("rr_left", int'(snooze_left), 0);
      tick_at(hms(12, 0, 0));
      check("rr_nomatch", int'(state), 0);

      for (int n = 0; n < 4000; n++) begin
         sec_tick = ($urandom_range(0, 2) == 0);
         if (m_st == 2 && $urandom_range(0, 9) < 4) clock_inp = from_tod(m_tgt);
         else clock_inp = pool[$urandom_range(0, 7)];
         wr_en     = ($urandom_range(0, 11) == 0);
         wr_slot   = SW'($urandom_range(0, NS - 1));
         wr_time   = pool[$urandom_range(0, 7)];
         wr_enable = ($urandom_range(0, 3) != 0);
         dismiss   = (m_st != 0) && ($urandom_range(0, 39) == 0);
         snooze    = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0; sec_tick = 1'b0; wr_en = 1'b0; dismiss = 1'b0; snooze = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
